// File: rtl/tl_sensor_cond.sv
// Conditions four raw loop detectors into the TA/TAL/TB/TBL requests.
// Each lane synchronises, debounces, holds through a gap-out, and caps at max-green.
module tl_sensor_lane #(
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_GREEN  = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic det,
  input  logic green,
  output logic t
);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYCLES);
  localparam logic [CNT_W-1:0] MAX_LD   = CNT_W'(MAX_GREEN);

  logic             s1, s2, deb;
  logic [CNT_W-1:0] dcnt, gcnt, mcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      deb  <= 1'b0;
      dcnt <= '0;
      gcnt <= '0;
      mcnt <= '0;
    end else begin
      s1 <= det;
      s2 <= s1;
      // any sample agreeing with the current level restarts the debounce run
      if (s2 == deb)
        dcnt <= '0;
      else if (dcnt == DEB_LAST) begin
        deb  <= s2;
        dcnt <= '0;
      end else
        dcnt <= dcnt + CNT_W'(1);
      if (deb)
        gcnt <= GAP_LD;
      else if (gcnt != '0)
        gcnt <= gcnt - CNT_W'(1);
      if (!green)
        mcnt <= '0;
      else if (mcnt != MAX_LD)
        mcnt <= mcnt + CNT_W'(1);
    end
  end

  // purely a decode of flops: presence masked by the max-green cap
  assign t = (deb | (gcnt != '0)) & (mcnt != MAX_LD);
endmodule

module tl_sensor_cond #(
  parameter int CNT_W      = 16,
  parameter int DEB_CYCLES = 4,
  parameter int GAP_CYCLES = 8,
  parameter int MAX_GREEN  = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       det_a,
  input  logic       det_al,
  input  logic       det_b,
  input  logic       det_bl,
  input  logic [2:0] Q,
  output logic       TA,
  output logic       TAL,
  output logic       TB,
  output logic       TBL
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0] det_v, green_v, t_v;

  assign det_v   = {det_bl, det_b, det_al, det_a};
  // lane order A, AL, B, BL matches green codes 000, 010, 100, 110
  assign green_v = {Q == 3'b110, Q == 3'b100, Q == 3'b010, Q == 3'b000};

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    tl_sensor_lane #(
      .CNT_W(CNT_W), .DEB_CYCLES(DEB_CYCLES),
      .GAP_CYCLES(GAP_CYCLES), .MAX_GREEN(MAX_GREEN)
    ) u_lane (
      .clk  (clk),
      .reset(reset),
      .det  (det_v[i]),
      .green(green_v[i]),
      .t    (t_v[i])
    );
  end

  assign {TBL, TB, TAL, TA} = t_v;
endmodule

// File: tb/tb_tl_sensor_cond.sv
// Directed-vector bench for tl_sensor_cond with default parameters.
module tb_tl_sensor_cond;
  logic       clk = 1'b0;
  logic       reset, det_a, det_al, det_b, det_bl;
  logic [2:0] Q;
  logic       TA, TAL, TB, TBL;
  int         n_run = 0, n_fail = 0;
  int         cnt;

  tl_sensor_cond dut (
    .clk(clk), .reset(reset), .det_a(det_a), .det_al(det_al),
    .det_b(det_b), .det_bl(det_bl), .Q(Q),
    .TA(TA), .TAL(TAL), .TB(TB), .TBL(TBL)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_run++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one active edge, then settle before sampling / driving
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    reset = 1'b1; Q = 3'b100;
    {det_a, det_al, det_b, det_bl} = 4'b1111;
    #1;
    // 1: reset, then first rise 6 edges after release
    step(3);
    chk("rst_ta", TA, 0); chk("rst_tal", TAL, 0);
    chk("rst_tb", TB, 0); chk("rst_tbl", TBL, 0);
    reset = 1'b0;
    step(5);
    chk("rise_ta_e4", TA, 0);
    step(1);
    chk("rise_ta_e5", TA, 1); chk("rise_tal_e5", TAL, 1);
    chk("rise_tb_e5", TB, 1); chk("rise_tbl_e5", TBL, 1);
    step(13);
    chk("capb_tb_e18", TB, 1);
    step(1);
    chk("capb_tb_e19", TB, 0); chk("capb_ta_e19", TA, 1);

    // 2: glitch rejection
    det_a = 1'b0;
    step(20);
    chk("glitch_idle", TA, 0);
    det_a = 1'b1; cnt = 0;
    for (int i = 0; i < 3; i++) begin step(1); cnt += TA; end
    det_a = 1'b0;
    for (int i = 0; i < 20; i++) begin step(1); cnt += TA; end
    chk("glitch3_hi", cnt, 0);
    det_a = 1'b1; cnt = 0;
    for (int i = 0; i < 4; i++) begin step(1); cnt += TA; end
    det_a = 1'b0;
    for (int i = 0; i < 30; i++) begin step(1); cnt += TA; end
    chk("pulse4_hi", cnt, 12);

    // 3: gap-out hold and re-detect during gap
    det_a = 1'b1;
    step(10);
    chk("gap_pre", TA, 1);
    det_a = 1'b0;
    step(13);
    chk("gap_e12", TA, 1);
    step(1);
    chk("gap_e13", TA, 0);
    det_a = 1'b1;
    step(10);
    chk("redet_pre", TA, 1);
    det_a = 1'b0; cnt = 0;
    for (int i = 0; i < 4; i++) begin step(1); cnt += (TA == 1'b0); end
    det_a = 1'b1;
    for (int i = 0; i < 20; i++) begin step(1); cnt += (TA == 1'b0); end
    chk("redet_lows", cnt, 0);

    // 4: max-green on AL, release on odd code
    Q = 3'b010;
    step(19);
    chk("cap_tal_e18", TAL, 1);
    step(1);
    chk("cap_tal_e19", TAL, 0); chk("cap_ta_e19", TA, 1);
    step(5);
    chk("cap_tal_hold", TAL, 0);
    Q = 3'b011;
    step(1);
    chk("cap_tal_rel", TAL, 1);

    // 5: independence under Q=BL
    Q = 3'b110;
    step(30);
    chk("ind_ta", TA, 1); chk("ind_tal", TAL, 1);
    chk("ind_tb", TB, 1); chk("ind_tbl", TBL, 0);

    // 6: reset while TB is in gap-out
    Q = 3'b001;
    det_b = 1'b0;
    step(9);
    chk("rst6_gap", TB, 1);
    reset = 1'b1; det_b = 1'b1;
    step(1);
    chk("rst6_tb", TB, 0);
    reset = 1'b0;
    step(5);
    chk("rst6_e4", TB, 0);
    step(1);
    chk("rst6_e5", TB, 1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
